// File: rtl/ascon_stream_ctrl_if.sv
// Stream bundle between the register/OBI side, ascon_stream_ctrl and ascon_core.
// The slave modport is the controller's view; master is the view of its surroundings.
interface ascon_stream_ctrl_if #(
  parameter int unsigned CCW = 64
);
  logic [31:0]      word_i;
  logic             word_valid_i;
  logic             word_ready_o;
  logic [1:0]       word_type_i;
  logic [2:0]       word_bytes_i;
  logic             word_last_i;
  logic             word_eoi_i;

  logic [CCW-1:0]   bdi_o;
  logic [CCW/8-1:0] bdi_valid_o;
  logic             bdi_ready_i;
  logic [1:0]       bdi_type_o;
  logic             bdi_eot_o;
  logic             bdi_eoi_o;

  logic [CCW-1:0]   bdo_i;
  logic [CCW/8-1:0] bdo_keep_i;
  logic             bdo_valid_i;
  logic             bdo_ready_o;
  logic             bdo_eot_i;

  logic [31:0]      out_word_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_last_o;

  modport slave (
    input  word_i, word_valid_i, word_type_i, word_bytes_i, word_last_i, word_eoi_i,
    output word_ready_o,
    output bdi_o, bdi_valid_o, bdi_type_o, bdi_eot_o, bdi_eoi_o,
    input  bdi_ready_i,
    input  bdo_i, bdo_keep_i, bdo_valid_i, bdo_eot_i,
    output bdo_ready_o,
    output out_word_o, out_valid_o, out_last_o,
    input  out_ready_i
  );

  modport master (
    output word_i, word_valid_i, word_type_i, word_bytes_i, word_last_i, word_eoi_i,
    input  word_ready_o,
    input  bdi_o, bdi_valid_o, bdi_type_o, bdi_eot_o, bdi_eoi_o,
    output bdi_ready_i,
    output bdo_i, bdo_keep_i, bdo_valid_i, bdo_eot_i,
    input  bdo_ready_o,
    input  out_word_o, out_valid_o, out_last_o,
    output out_ready_i
  );
endinterface

// File: rtl/ascon_stream_ctrl.sv
// 32-bit word <-> CCW-bit block bridge for ascon_core: packs typed input words into
// masked core blocks, unpacks core output blocks into words, and sequences the operation.
module ascon_stream_ctrl #(
  parameter int unsigned CCW = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  ascon_stream_ctrl_if.slave bus,
  input  logic               core_done_i,
  input  logic               core_auth_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               auth_o
);

  localparam int unsigned WPB = CCW / 32;
  localparam int unsigned NB  = CCW / 8;
  localparam int unsigned KW  = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [1:0] {D_AD = 2'd0, D_MSG = 2'd1, D_TAG = 2'd2} e_data_type;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} e_state;

  e_state state_q, state_d;
  logic   done_seen_q;
  logic   auth_q;

  // pack path state
  logic [CCW-1:0] pk_data_q;
  logic [NB-1:0]  pk_mask_q;
  e_data_type     pk_type_q;
  logic           pk_eot_q;
  logic           pk_eoi_q;
  logic [KW-1:0]  pk_k_q;
  logic           blk_pend_q;

  // unpack path state
  logic [CCW-1:0] ub_data_q;
  logic [WPB-1:0] ub_pend_q;
  logic           ub_eot_q;

  logic           word_acc, word_drop, last_lane, pend_take;
  logic [3:0]     byte_en;
  logic [31:0]    word_m;
  logic [WPB-1:0] lane_has;
  logic [KW-1:0]  cur_lane;
  logic           lane_found;
  logic           capture, advance, unp_empty, active;

  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign word_acc  = bus.word_valid_i & bus.word_ready_o;
  assign word_drop = (bus.word_type_i == 2'd3);
  assign last_lane = (pk_k_q == KW'(WPB - 1));
  assign pend_take = blk_pend_q & bus.bdi_ready_i;

  // Byte count only matters on the last word of a type; out-of-range counts mean a full word.
  always_comb begin
    byte_en = 4'hF;
    word_m  = '0;
    if (bus.word_last_i) begin
      case (bus.word_bytes_i)
        3'd1:    byte_en = 4'h1;
        3'd2:    byte_en = 4'h3;
        3'd3:    byte_en = 4'h7;
        default: byte_en = 4'hF;
      endcase
    end
    for (int unsigned j = 0; j < 4; j++) begin
      word_m[8*j +: 8] = byte_en[j] ? bus.word_i[8*j +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pk_data_q  <= '0;
      pk_mask_q  <= '0;
      pk_type_q  <= D_AD;
      pk_eot_q   <= 1'b0;
      pk_eoi_q   <= 1'b0;
      pk_k_q     <= '0;
      blk_pend_q <= 1'b0;
    end else if (abort_i) begin
      pk_data_q  <= '0;
      pk_mask_q  <= '0;
      pk_type_q  <= D_AD;
      pk_eot_q   <= 1'b0;
      pk_eoi_q   <= 1'b0;
      pk_k_q     <= '0;
      blk_pend_q <= 1'b0;
    end else if (pend_take) begin
      // Clearing on hand-off keeps unfilled bytes of the next block at zero.
      pk_data_q  <= '0;
      pk_mask_q  <= '0;
      pk_eot_q   <= 1'b0;
      pk_eoi_q   <= 1'b0;
      blk_pend_q <= 1'b0;
    end else if (word_acc && !word_drop) begin
      pk_data_q[32*pk_k_q +: 32] <= word_m;
      pk_mask_q[4*pk_k_q +: 4]   <= byte_en;
      pk_type_q                  <= e_data_type'(bus.word_type_i);
      pk_eot_q                   <= bus.word_last_i;
      pk_eoi_q                   <= bus.word_last_i & bus.word_eoi_i;
      if (bus.word_last_i || last_lane) begin
        blk_pend_q <= 1'b1;
        pk_k_q     <= '0;
      end else begin
        pk_k_q     <= pk_k_q + KW'(1);
      end
    end
  end

  assign bus.word_ready_o = (state_q == S_RUN) & ~blk_pend_q;
  assign bus.bdi_o        = pk_data_q;
  assign bus.bdi_valid_o  = blk_pend_q ? pk_mask_q : '0;
  assign bus.bdi_type_o   = pk_type_q;
  assign bus.bdi_eot_o    = blk_pend_q & pk_eot_q;
  assign bus.bdi_eoi_o    = blk_pend_q & pk_eoi_q;

  // Unpack: pending-lane bitmap, emitted lowest lane first.
  always_comb begin
    lane_has   = '0;
    cur_lane   = '0;
    lane_found = 1'b0;
    for (int unsigned i = 0; i < WPB; i++) begin
      lane_has[i] = |bus.bdo_keep_i[4*i +: 4];
      if (ub_pend_q[i] && !lane_found) begin
        cur_lane   = KW'(i);
        lane_found = 1'b1;
      end
    end
  end

  assign unp_empty = (ub_pend_q == '0);
  assign capture   = bus.bdo_valid_i & bus.bdo_ready_o;
  assign advance   = bus.out_valid_o & bus.out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ub_data_q <= '0;
      ub_pend_q <= '0;
      ub_eot_q  <= 1'b0;
    end else if (abort_i) begin
      ub_data_q <= '0;
      ub_pend_q <= '0;
      ub_eot_q  <= 1'b0;
    end else if (capture) begin
      ub_data_q <= bus.bdo_i;
      ub_pend_q <= lane_has;
      ub_eot_q  <= bus.bdo_eot_i;
    end else if (advance) begin
      ub_pend_q <= ub_pend_q & (ub_pend_q - WPB'(1));
    end
  end

  assign bus.bdo_ready_o = active & unp_empty;
  assign bus.out_valid_o = ~unp_empty;
  assign bus.out_word_o  = ub_data_q[32*cur_lane +: 32];
  assign bus.out_last_o  = ub_eot_q & ~unp_empty & ((ub_pend_q & (ub_pend_q - WPB'(1))) == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (pend_take && pk_eoi_q) state_d = S_DRAIN;
      S_DRAIN: if (unp_empty && (done_seen_q || core_done_i)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      done_seen_q <= 1'b0;
      auth_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (abort_i || state_q == S_IDLE || state_q == S_DONE) begin
        done_seen_q <= 1'b0;
      end else if (core_done_i) begin
        done_seen_q <= 1'b1;
      end
      if (abort_i || (state_q == S_IDLE && start_i)) begin
        auth_q <= 1'b0;
      end else if (core_done_i && active) begin
        auth_q <= core_auth_i;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign auth_o = auth_q;

endmodule

// File: tb/tb_ascon_stream_ctrl.sv
// Directed bench for ascon_stream_ctrl: a CCW=64 and a CCW=128 instance share one clock.
module tb_ascon_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start64, abort64, cdone64, cauth64, busy64, done64, auth64;
  logic start128, abort128, cdone128, cauth128, busy128, done128, auth128;

  ascon_stream_ctrl_if #(.CCW(64))  b64 ();
  ascon_stream_ctrl_if #(.CCW(128)) b128 ();

  ascon_stream_ctrl #(.CCW(64)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start64), .abort_i(abort64), .bus(b64),
    .core_done_i(cdone64), .core_auth_i(cauth64),
    .busy_o(busy64), .done_o(done64), .auth_o(auth64)
  );

  ascon_stream_ctrl #(.CCW(128)) u_dut128 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start128), .abort_i(abort128), .bus(b128),
    .core_done_i(cdone128), .core_auth_i(cauth128),
    .busy_o(busy128), .done_o(done128), .auth_o(auth128)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    {start64, abort64, cdone64, cauth64}     = '0;
    {start128, abort128, cdone128, cauth128} = '0;
    b64.word_i = '0;  b64.word_valid_i = 1'b0; b64.word_type_i = 2'd0; b64.word_bytes_i = 3'd4;
    b64.word_last_i = 1'b0; b64.word_eoi_i = 1'b0; b64.bdi_ready_i = 1'b0;
    b64.bdo_i = '0; b64.bdo_keep_i = '0; b64.bdo_valid_i = 1'b0; b64.bdo_eot_i = 1'b0;
    b64.out_ready_i = 1'b0;
    b128.word_i = '0; b128.word_valid_i = 1'b0; b128.word_type_i = 2'd0; b128.word_bytes_i = 3'd4;
    b128.word_last_i = 1'b0; b128.word_eoi_i = 1'b0; b128.bdi_ready_i = 1'b0;
    b128.bdo_i = '0; b128.bdo_keep_i = '0; b128.bdo_valid_i = 1'b0; b128.bdo_eot_i = 1'b0;
    b128.out_ready_i = 1'b0;
  endtask

  initial begin
    init_inputs();
    tick();
    tick();
    chk("rst_busy", busy64, 1'b0);
    chk("rst_wready", b64.word_ready_o, 1'b0);
    chk("rst_bdi_valid", b64.bdi_valid_o, 8'h00);
    chk("rst_bdo_ready", b64.bdo_ready_o, 1'b0);
    chk("rst_out_valid", b64.out_valid_o, 1'b0);
    chk("rst_out_word", b64.out_word_o, 32'h0);
    chk("rst_done_auth", {done64, auth64}, 2'b00);
    rst_n = 1'b1;
    tick();

    // AD stream of four words -> two blocks, with a five-cycle core stall on the first
    start64 = 1'b1; tick(); start64 = 1'b0;
    chk("start_busy", busy64, 1'b1);
    chk("start_wready", b64.word_ready_o, 1'b1);
    chk("start_bdo_ready", b64.bdo_ready_o, 1'b1);
    b64.word_valid_i = 1'b1; b64.word_i = 32'h11111111; tick();
    b64.word_i = 32'h22222222; tick();
    b64.word_i = 32'h33333333;
    chk("blk1_wready", b64.word_ready_o, 1'b0);
    chk("blk1_mask", b64.bdi_valid_o, 8'hFF);
    chk("blk1_data", b64.bdi_o, 64'h22222222_11111111);
    chk("blk1_type_eot_eoi", {b64.bdi_type_o, b64.bdi_eot_o, b64.bdi_eoi_o}, 4'b00_0_0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_wready", b64.word_ready_o, 1'b0);
      chk("stall_data", b64.bdi_o, 64'h22222222_11111111);
      chk("stall_mask", b64.bdi_valid_o, 8'hFF);
    end
    b64.bdi_ready_i = 1'b1; tick(); b64.bdi_ready_i = 1'b0;
    chk("xfer_mask_clear", b64.bdi_valid_o, 8'h00);
    chk("xfer_wready_back", b64.word_ready_o, 1'b1);
    tick();
    b64.word_i = 32'h44444444; b64.word_last_i = 1'b1; tick();
    b64.word_valid_i = 1'b0; b64.word_last_i = 1'b0;
    chk("blk2_data", b64.bdi_o, 64'h44444444_33333333);
    chk("blk2_mask", b64.bdi_valid_o, 8'hFF);
    chk("blk2_type_eot_eoi", {b64.bdi_type_o, b64.bdi_eot_o, b64.bdi_eoi_o}, 4'b00_1_0);
    b64.bdi_ready_i = 1'b1; tick(); b64.bdi_ready_i = 1'b0;

    // illegal type dropped, then a 3-byte MSG word closing the input
    b64.word_valid_i = 1'b1; b64.word_i = 32'hDEADBEEF; b64.word_type_i = 2'd3; tick();
    b64.word_i = 32'h55667788; b64.word_type_i = 2'd1; b64.word_bytes_i = 3'd3;
    b64.word_last_i = 1'b1; b64.word_eoi_i = 1'b1; tick();
    b64.word_valid_i = 1'b0; b64.word_last_i = 1'b0; b64.word_eoi_i = 1'b0;
    b64.word_type_i = 2'd0; b64.word_bytes_i = 3'd4;
    chk("msg_data", b64.bdi_o, 64'h00000000_00667788);
    chk("msg_mask", b64.bdi_valid_o, 8'h07);
    chk("msg_type_eot_eoi", {b64.bdi_type_o, b64.bdi_eot_o, b64.bdi_eoi_o}, 4'b01_1_1);
    b64.bdi_ready_i = 1'b1; tick(); b64.bdi_ready_i = 1'b0;
    chk("drain_busy", busy64, 1'b1);
    chk("drain_wready", b64.word_ready_o, 1'b0);
    chk("drain_bdo_ready", b64.bdo_ready_o, 1'b1);

    // one-lane output block, then done arriving while that word is still pending
    b64.bdo_i = 64'hBBBBBBBB_AAAAAAAA; b64.bdo_keep_i = 8'h0F; b64.bdo_eot_i = 1'b1;
    b64.bdo_valid_i = 1'b1; tick(); b64.bdo_valid_i = 1'b0; b64.bdo_eot_i = 1'b0;
    chk("unp1_valid", b64.out_valid_o, 1'b1);
    chk("unp1_word", b64.out_word_o, 32'hAAAAAAAA);
    chk("unp1_last", b64.out_last_o, 1'b1);
    chk("unp1_bdo_ready", b64.bdo_ready_o, 1'b0);
    tick();
    chk("unp1_hold_word", b64.out_word_o, 32'hAAAAAAAA);
    cdone64 = 1'b1; cauth64 = 1'b1; tick(); cdone64 = 1'b0; cauth64 = 1'b0;
    chk("early_done_held", done64, 1'b0);
    chk("early_done_word", b64.out_valid_o, 1'b1);
    b64.out_ready_i = 1'b1; tick(); b64.out_ready_i = 1'b0;
    chk("unp1_taken", b64.out_valid_o, 1'b0);
    chk("unp1_done_not_yet", done64, 1'b0);
    tick();
    chk("done_pulse", done64, 1'b1);
    chk("done_auth", auth64, 1'b1);
    chk("done_no_extra_word", b64.out_valid_o, 1'b0);
    tick();
    chk("idle_busy", busy64, 1'b0);
    chk("idle_done", done64, 1'b0);
    chk("idle_auth_held", auth64, 1'b1);

    // second operation: auth clears, two-lane output block, abort mid-block
    start64 = 1'b1; tick(); start64 = 1'b0;
    chk("restart_auth", auth64, 1'b0);
    b64.bdo_i = 64'hDDDDDDDD_CCCCCCCC; b64.bdo_keep_i = 8'hFF; b64.bdo_valid_i = 1'b1;
    tick(); b64.bdo_valid_i = 1'b0;
    chk("unp2_w0", b64.out_word_o, 32'hCCCCCCCC);
    chk("unp2_w0_last", b64.out_last_o, 1'b0);
    b64.out_ready_i = 1'b1; tick();
    chk("unp2_w1", b64.out_word_o, 32'hDDDDDDDD);
    chk("unp2_w1_valid_last", {b64.out_valid_o, b64.out_last_o}, 2'b10);
    tick(); b64.out_ready_i = 1'b0;
    chk("unp2_empty", {b64.out_valid_o, b64.bdo_ready_o}, 2'b01);
    b64.word_valid_i = 1'b1; b64.word_i = 32'h12345678; tick(); b64.word_valid_i = 1'b0;
    chk("partial_no_valid", b64.bdi_valid_o, 8'h00);
    abort64 = 1'b1; tick(); abort64 = 1'b0;
    chk("abort_busy", busy64, 1'b0);
    chk("abort_wready", b64.word_ready_o, 1'b0);
    start64 = 1'b1; abort64 = 1'b1; tick(); start64 = 1'b0; abort64 = 1'b0;
    chk("abort_beats_start", busy64, 1'b0);

    // CCW=128: three MSG words, last with 2 bytes and eoi
    start128 = 1'b1; tick(); start128 = 1'b0;
    b128.word_valid_i = 1'b1; b128.word_type_i = 2'd1;
    b128.word_i = 32'h01020304; tick();
    b128.word_i = 32'h05060708; tick();
    b128.word_i = 32'h090A0B0C; b128.word_bytes_i = 3'd2;
    b128.word_last_i = 1'b1; b128.word_eoi_i = 1'b1; tick();
    b128.word_valid_i = 1'b0; b128.word_last_i = 1'b0; b128.word_eoi_i = 1'b0;
    b128.word_bytes_i = 3'd4; b128.word_type_i = 2'd0;
    chk("w128_data", b128.bdi_o, 128'h00000000_00000B0C_05060708_01020304);
    chk("w128_mask", b128.bdi_valid_o, 16'h03FF);
    chk("w128_type_eot_eoi", {b128.bdi_type_o, b128.bdi_eot_o, b128.bdi_eoi_o}, 4'b01_1_1);
    b128.bdi_ready_i = 1'b1; tick(); b128.bdi_ready_i = 1'b0;
    chk("w128_drain", {busy128, b128.word_ready_o, b128.bdo_ready_o}, 3'b101);
    abort128 = 1'b1; tick(); abort128 = 1'b0;
    start128 = 1'b1; tick(); start128 = 1'b0;
    b128.word_valid_i = 1'b1;
    b128.word_i = 32'hA0A0A0A0; tick();
    b128.word_i = 32'hB0B0B0B0; tick();
    b128.word_valid_i = 1'b0;
    abort128 = 1'b1; tick(); abort128 = 1'b0;
    chk("w128_abort_busy", busy128, 1'b0);
    chk("w128_abort_mask", b128.bdi_valid_o, 16'h0000);
    start128 = 1'b1; tick(); start128 = 1'b0;
    b128.word_valid_i = 1'b1; b128.word_i = 32'hC0C0C0C0; b128.word_last_i = 1'b1; tick();
    b128.word_valid_i = 1'b0; b128.word_last_i = 1'b0;
    chk("w128_lane0_data", b128.bdi_o, 128'h00000000_00000000_00000000_C0C0C0C0);
    chk("w128_lane0_mask", b128.bdi_valid_o, 16'h000F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
